// File: rtl/msu_audio_stream.sv
// MSU-1 audio stream stage: fetches .pcm sectors from the HPS into a word FIFO
// and plays volume-scaled 16-bit stereo samples at 44.1 kHz.
// Optional build macro: MSU_VOL_RAMP_EN (internal volume ramps 1 LSB per sample).
module msu_audio_stream #(
  parameter int unsigned FifoAw     = 9,
  parameter int unsigned BurstWords = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ce_44k_i,
  input  logic        trig_play_i,
  input  logic [15:0] track_i,
  input  logic        ctrl_play_i,
  input  logic        ctrl_repeat_i,
  input  logic [7:0]  volume_i,
  input  logic        track_mounting_i,
  input  logic [15:0] hps_din_i,
  input  logic        hps_we_i,
  input  logic        hps_eof_i,
  output logic        hps_req_o,
  output logic [31:0] hps_addr_o,
  output logic [15:0] audio_l_o,
  output logic [15:0] audio_r_o,
  output logic        playing_o,
  output logic        track_missing_o
);

  localparam int unsigned Depth      = 2 ** FifoAw;
  localparam int unsigned CntW       = FifoAw + 1;
  localparam int unsigned BcW        = $clog2(BurstWords + 1);
  localparam logic [31:0] BurstBytes = 32'(BurstWords * 2);

  typedef enum logic [2:0] {StIdle, StMount, StHeader, StFill, StPlay, StDrain} state_e;

  state_e            state_q, state_d;
  logic [15:0]       mem_q [Depth];
  logic [FifoAw-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, free_w;
  logic              busy_q;  // a burst is outstanding at the HPS
  logic [BcW-1:0]    burst_cnt_q;
  logic [1:0]        hdr_idx_q;
  logic [31:0]       loop_q, next_addr_q, req_addr_q;
  logic [31:0]       loop_addr_w, eof_pos_w, restart_addr_w;
  logic [15:0]       track_q, audio_l_q, audio_r_q;
  logic              req_q, missing_q;
  logic [7:0]        vol_eff;
  logic signed [24:0] prod_l, prod_r;

  logic stream_st, word_in, fifo_wr, hdr_bad, can_pop, pop, eof_in;
  logic issue_mount, issue_fill, burst_last;

  assign stream_st   = (state_q == StHeader) || (state_q == StFill) || (state_q == StPlay);
  assign word_in     = hps_we_i && stream_st && !trig_play_i;
  assign free_w      = CntW'(Depth) - count_q;
  assign fifo_wr     = word_in && (state_q != StHeader) && (count_q != CntW'(Depth));
  assign hdr_bad     = word_in && (state_q == StHeader) &&
                       (((hdr_idx_q == 2'd0) && (hps_din_i != 16'h534D)) ||
                        ((hdr_idx_q == 2'd1) && (hps_din_i != 16'h3155)));
  assign can_pop     = count_q >= CntW'(2);
  assign pop         = ce_44k_i && ctrl_play_i && can_pop && !trig_play_i &&
                       ((state_q == StPlay) || (state_q == StDrain));
  assign eof_in      = hps_eof_i && !trig_play_i &&
                       ((state_q == StFill) || (state_q == StPlay));
  assign issue_mount = (state_q == StMount) && !track_mounting_i && !trig_play_i;
  assign issue_fill  = ((state_q == StFill) || (state_q == StPlay)) && !busy_q &&
                       (free_w >= CntW'(BurstWords)) && !hps_eof_i && !trig_play_i;
  assign burst_last  = word_in && busy_q && (burst_cnt_q == BcW'(BurstWords - 1));

  // A loop point at or beyond the end of file falls back to the first sample.
  assign loop_addr_w    = 32'd8 + {loop_q[29:0], 2'b00};
  assign eof_pos_w      = req_addr_q + 32'({burst_cnt_q, 1'b0});
  assign restart_addr_w = (loop_addr_w >= eof_pos_w) ? 32'd8 : loop_addr_w;

  // Stream sequencing; a play trigger restarts from any state.
  always_comb begin
    state_d = state_q;
    if (trig_play_i) begin
      state_d = StMount;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StMount:  if (!track_mounting_i) state_d = StHeader;
        StHeader: begin
          if (hdr_bad) state_d = StIdle;
          else if (word_in && (hdr_idx_q == 2'd3)) state_d = StFill;
        end
        StFill: begin
          if (eof_in) state_d = ctrl_repeat_i ? StPlay : StDrain;
          else if (count_q >= CntW'(BurstWords)) state_d = StPlay;
        end
        StPlay:   if (eof_in && !ctrl_repeat_i) state_d = StDrain;
        StDrain:  if (ce_44k_i && ctrl_play_i && !can_pop) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // HPS request, burst tracking, header parsing and status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q       <= 1'b0;
      req_addr_q  <= '0;
      next_addr_q <= '0;
      busy_q      <= 1'b0;
      burst_cnt_q <= '0;
      hdr_idx_q   <= '0;
      loop_q      <= '0;
      track_q     <= '0;
      missing_q   <= 1'b0;
    end else begin
      req_q <= issue_mount || issue_fill;
      if (trig_play_i) begin
        busy_q      <= 1'b0;
        burst_cnt_q <= '0;
        hdr_idx_q   <= '0;
        loop_q      <= '0;
        next_addr_q <= '0;
        track_q     <= track_i;
        missing_q   <= 1'b0;
      end else begin
        if (issue_mount) begin
          req_addr_q  <= '0;
          next_addr_q <= BurstBytes;
          busy_q      <= 1'b1;
          burst_cnt_q <= '0;
        end else if (issue_fill) begin
          req_addr_q  <= next_addr_q;
          next_addr_q <= next_addr_q + BurstBytes;
          busy_q      <= 1'b1;
          burst_cnt_q <= '0;
        end
        if (word_in && busy_q) begin
          burst_cnt_q <= burst_cnt_q + BcW'(1);
          if (burst_last) busy_q <= 1'b0;
        end
        if (eof_in) begin
          busy_q <= 1'b0;
          if (ctrl_repeat_i) next_addr_q <= restart_addr_w;
        end
        if (word_in && (state_q == StHeader)) begin
          hdr_idx_q <= hdr_idx_q + 2'd1;
          if (hdr_idx_q == 2'd2) loop_q[15:0]  <= hps_din_i;
          if (hdr_idx_q == 2'd3) loop_q[31:16] <= hps_din_i;
        end
        if (hdr_bad) begin
          missing_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      end
    end
  end

  // FIFO storage; no reset needed as occupancy is tracked separately.
  always_ff @(posedge clk_i) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= hps_din_i;
  end

  // FIFO pointers and occupancy; one sample pops an L/R word pair.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (trig_play_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + FifoAw'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + FifoAw'(2);
      count_q <= count_q + CntW'(fifo_wr) - (pop ? CntW'(2) : CntW'(0));
    end
  end

`ifdef MSU_VOL_RAMP_EN
  logic [7:0] vol_q;

  // Volume slews one step per sample toward the requested level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 vol_q <= '0;
    else if (trig_play_i)      vol_q <= '0;
    else if (ce_44k_i) begin
      if (vol_q < volume_i)      vol_q <= vol_q + 8'd1;
      else if (vol_q > volume_i) vol_q <= vol_q - 8'd1;
    end
  end
  assign vol_eff = vol_q;
`else
  assign vol_eff = volume_i;
`endif

  assign prod_l = $signed(mem_q[rd_ptr_q]) * $signed({1'b0, vol_eff});
  assign prod_r = $signed(mem_q[rd_ptr_q + FifoAw'(1)]) * $signed({1'b0, vol_eff});

  // Sample output: scaled pair on a pop, silence on pause or underrun.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      audio_l_q <= '0;
      audio_r_q <= '0;
    end else if (trig_play_i) begin
      audio_l_q <= '0;
      audio_r_q <= '0;
    end else if (ce_44k_i && ((state_q == StPlay) || (state_q == StDrain))) begin
      audio_l_q <= pop ? prod_l[23:8] : 16'h0000;
      audio_r_q <= pop ? prod_r[23:8] : 16'h0000;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{track_q, prod_l[24], prod_l[7:0], prod_r[24], prod_r[7:0]};

  assign hps_req_o       = req_q;
  assign hps_addr_o      = req_addr_q;
  assign audio_l_o       = audio_l_q;
  assign audio_r_o       = audio_r_q;
  assign playing_o       = (state_q != StIdle);
  assign track_missing_o = missing_q;

endmodule
